mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the pipelined RISC-V core. It shares a single unified single-ported memory between the IF stage (instruction fetch) and the MEM stage (loads and stores). It sequences each access with a request/ready handshake and returns stall signals to the pipeline. It guarantees forward progress for fetch under a sustained load/store stream and aborts hung memory accesses with a bus error.

---
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: one request/ready handshake to a single-ported memory.
//   master : arbiter side, drives m_req/m_we/m_be/m_addr/m_wdata, receives m_rdata/m_ready
//   slave  : memory side, the mirror image
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  m_req;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_ready;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) to one-port memory arbiter with fetch anti-starvation and
// access timeout.
//   clk, rst              : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request in; if_rdata/if_valid registered response
//   d_req/d_we/d_be/...   : load/store request in; d_rdata/d_valid registered response
//   m                     : memory bus (mem_arbiter_if.master), all outputs registered
//   stall_if, stall_mem   : combinational pipeline freezes
//   bus_err               : pulses with the valid of an access that timed out
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  mem_arbiter_if.master       m,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned STV_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t              state, state_nxt;
  logic                m_req_q, m_req_nxt;
  logic                m_we_q, m_we_nxt;
  logic [BE_W-1:0]     m_be_q, m_be_nxt;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_nxt;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_nxt;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_nxt;
  logic                if_valid_q, if_valid_nxt;
  logic                d_valid_q, d_valid_nxt;
  logic                bus_err_q, bus_err_nxt;
  logic [STV_W-1:0]    starve_q, starve_nxt;
  logic [WAIT_W-1:0]   wait_q, wait_nxt;
  logic                starved;
  logic                timed_out;

  assign starved   = (starve_q == STV_W'(STARVE_MAX));
  assign timed_out = (wait_q == WAIT_W'(TIMEOUT));

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    m_req_nxt    = m_req_q;
    m_we_nxt     = m_we_q;
    m_be_nxt     = m_be_q;
    m_addr_nxt   = m_addr_q;
    m_wdata_nxt  = m_wdata_q;
    if_rdata_nxt = if_rdata_q;
    d_rdata_nxt  = d_rdata_q;
    if_valid_nxt = 1'b0;
    d_valid_nxt  = 1'b0;
    bus_err_nxt  = 1'b0;
    starve_nxt   = starve_q;
    wait_nxt     = wait_q;

    case (state)
      IDLE: begin
        // Data wins a tie unless fetch has already waited out STARVE_MAX data grants.
        if (if_req && (!d_req || starved)) begin
          state_nxt   = GNT_I;
          m_req_nxt   = 1'b1;
          m_we_nxt    = 1'b0;
          m_be_nxt    = '1;
          m_addr_nxt  = if_addr;
          m_wdata_nxt = '0;
          starve_nxt  = '0;
          wait_nxt    = WAIT_W'(1);
        end else if (d_req) begin
          state_nxt   = GNT_D;
          m_req_nxt   = 1'b1;
          m_we_nxt    = d_we;
          m_be_nxt    = d_be;
          m_addr_nxt  = d_addr;
          m_wdata_nxt = d_wdata;
          wait_nxt    = WAIT_W'(1);
          if (if_req && !starved) begin
            starve_nxt = starve_q + STV_W'(1);
          end
        end
      end

      GNT_I, GNT_D: begin
        if (m.m_ready || timed_out) begin
          state_nxt   = RESP;
          m_req_nxt   = 1'b0;
          wait_nxt    = '0;
          bus_err_nxt = !m.m_ready;
          if (state == GNT_I) begin
            if_valid_nxt = 1'b1;
            if (m.m_ready) begin
              if_rdata_nxt = m.m_rdata;
            end
          end else begin
            d_valid_nxt = 1'b1;
            if (m.m_ready && !m_we_q) begin
              d_rdata_nxt = m.m_rdata;
            end
          end
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      starve_q   <= '0;
      wait_q     <= '0;
    end else begin
      state      <= state_nxt;
      m_req_q    <= m_req_nxt;
      m_we_q     <= m_we_nxt;
      m_be_q     <= m_be_nxt;
      m_addr_q   <= m_addr_nxt;
      m_wdata_q  <= m_wdata_nxt;
      if_rdata_q <= if_rdata_nxt;
      d_rdata_q  <= d_rdata_nxt;
      if_valid_q <= if_valid_nxt;
      d_valid_q  <= d_valid_nxt;
      bus_err_q  <= bus_err_nxt;
      starve_q   <= starve_nxt;
      wait_q     <= wait_nxt;
    end
  end

  assign m.m_req   = m_req_q;
  assign m.m_we    = m_we_q;
  assign m.m_be    = m_be_q;
  assign m.m_addr  = m_addr_q;
  assign m.m_wdata = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;

  // Pipeline freezes until the owning port's valid arrives.
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences (starvation, async reset mid-access) and a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned TMO  = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          stall_if, stall_mem, bus_err;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m(mem_if),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- memory device and reference memory ----------------
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hA5A5_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] w,
                                    input logic [3:0] be);
    ref_mem[a] = merge(ref_rd(a), w, be);
  endfunction

  // Responder: ready after cur_lat extra wait cycles, or never; garbage data when not ready.
  int resp_lat   = 0;
  bit resp_never = 1'b0;
  bit resp_rand  = 1'b0;
  int rc_r       = 0;
  int cur_lat    = 0;
  bit cur_never  = 1'b0;

  initial begin
    logic rdy;
    mem_if.m_ready = 1'b0;
    mem_if.m_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_if.m_req && mem_if.m_ready && mem_if.m_we)
        dev_mem[mem_if.m_addr] = merge(dev_rd(mem_if.m_addr), mem_if.m_wdata, mem_if.m_be);
      #2;
      rdy = 1'b0;
      if (mem_if.m_req) begin
        rc_r++;
        if (rc_r == 1) begin
          if (resp_rand) begin
            cur_never = ($urandom_range(0, 11) == 0);
            cur_lat   = int'($urandom_range(0, 3));
          end else begin
            cur_never = resp_never;
            cur_lat   = resp_lat;
          end
        end
        rdy = !cur_never && (rc_r == cur_lat + 1);
      end else begin
        rc_r = 0;
      end
      mem_if.m_ready = rdy;
      mem_if.m_rdata = rdy ? dev_rd(mem_if.m_addr) : $urandom();
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;       // extra wait cycles, -1 = never ready
    logic [31:0] exp_rdata;
    int          exp_cyc;   // cycle of the valid pulse, request seen in cycle 0
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input int idx, input vec_t v);
    int got_cyc;
    int mreq_cnt;
    logic we_first;
    logic [2:0] vflags;
    logic [31:0] rd;
    got_cyc = -1; mreq_cnt = 0; we_first = 1'bx; vflags = '0; rd = '0;
    @(posedge clk); #1;
    resp_lat   = (v.lat < 0) ? 0 : v.lat;
    resp_never = (v.lat < 0);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c < 40 && got_cyc < 0; c++) begin
      @(negedge clk);
      if (c < 2) chk($sformatf("v%0d_stall_c%0d", idx, c), v.is_d ? stall_mem : stall_if, 1);
      if (mem_if.m_req) begin
        if (mreq_cnt == 0) we_first = mem_if.m_we;
        mreq_cnt++;
      end
      if (if_valid || d_valid) begin
        got_cyc = c;
        vflags  = {if_valid, d_valid, bus_err};
        rd      = v.is_d ? d_rdata : if_rdata;
      end
    end
    chk($sformatf("v%0d_valid_cycle", idx), 32'(got_cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_valid_flags", idx), 32'(vflags), 32'({!v.is_d, v.is_d, v.exp_err}));
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d_mreq_cycles", idx), 32'(mreq_cnt), 32'(v.exp_cyc - 1));
    chk($sformatf("v%0d_m_we", idx), 32'(we_first), 32'(v.is_d & v.we));
    if (v.is_d && v.we && !v.exp_err) ref_write(v.addr, v.wdata, v.be);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
  endtask

  // ---------------- random-phase model state ----------------
  bit          prev_if, prev_d, mreq_prev, pend, pend_to, g_d, exp_d, if_done, d_done;
  int          mstarve, rc_m;
  logic [31:0] exp_ird, exp_drd;

  initial begin
    int k, got, prevm;
    bit is_i;

    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,          0, 32'h0050_0093,  2, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF,  0, 32'h0000_0000,  2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,          0, 32'hDEAD_BEEF,  2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,          3, 32'hDEAD_BEEF,  5, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'h3, 32'h0000_0044, 32'h1122_3344,  1, 32'hDEAD_BEEF,  3, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0,          0, 32'hA5A5_3344,  2, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0,         -1, 32'hA5A5_3344, 16, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'hF, 32'h0000_0008, 32'h0,          2, 32'hA5A5_0008,  4, 1'b0};

    dev_mem[32'h0] = 32'h0050_0093;
    ref_mem[32'h0] = 32'h0050_0093;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ctl", 32'({mem_if.m_req, mem_if.m_we, mem_if.m_be}), 0);
    chk("rst_m_addr", mem_if.m_addr, 0);
    chk("rst_m_wdata", mem_if.m_wdata, 0);
    chk("rst_flags", 32'({if_valid, d_valid, bus_err}), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both requests held: data wins until fetch has waited SMAX data grants
    @(posedge clk); #1;
    resp_lat = 0; resp_never = 1'b0;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    k = 0; prevm = 0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      @(negedge clk);
      if (mem_if.m_req && prevm == 0) begin
        is_i = (mem_if.m_addr == 32'h80);
        chk($sformatf("starve_grant%0d_is_fetch", k), 32'(is_i), 32'((k % (SMAX + 1)) == SMAX));
        if (is_i) chk($sformatf("starve_clear%0d", k), 32'(dut.starve_q), 0);
        k++;
      end
      prevm = mem_if.m_req;
    end
    chk("starve_grant_count", 32'(k), 10);
    // let the last access finish
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (if_valid || d_valid) got = 1;
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Async reset in the second GNT_I cycle, then a fresh access
    #1;
    resp_never = 1'b1; if_req = 1'b1; if_addr = 32'h8;
    repeat (3) @(negedge clk);
    chk("rstmid_pre_mreq", 32'(mem_if.m_req), 1);
    rst = 1'b0;
    #1;
    chk("rstmid_async_mreq", 32'(mem_if.m_req), 0);
    chk("rstmid_flags", 32'({if_valid, d_valid, bus_err}), 0);
    chk("rstmid_if_rdata", if_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1; resp_never = 1'b0; resp_lat = 0;
    got = -1;
    for (int c = 0; c < 20 && got < 0; c++) begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        got = c;
        chk("rstmid_fresh_rdata", if_rdata, 32'hA5A5_0008);
        chk("rstmid_fresh_flags", 32'({if_valid, d_valid, bus_err}), 3'b100);
        chk("rstmid_d_rdata", d_rdata, 0);
      end
    end
    chk("rstmid_fresh_cycle", 32'(got), 2);
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized run against the transaction-level model
    resp_rand = 1'b1;
    exp_ird = 32'hA5A5_0008; exp_drd = 32'h0;
    mstarve = 0; rc_m = 0;
    prev_if = 1'b0; prev_d = 1'b0; mreq_prev = 1'b0; pend = 1'b0; pend_to = 1'b0;
    g_d = 1'b0; if_done = 1'b0; d_done = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (if_done) begin if_req = 1'b0; if_done = 1'b0; end
      if (d_done) begin d_req = 1'b0; d_done = 1'b0; end
      if (cyc < 1900) begin
        if (!if_req && $urandom_range(0, 3) != 0) begin
          if_req = 1'b1;
          if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!d_req && $urandom_range(0, 3) != 0) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_be = 4'($urandom_range(1, 15));
          d_addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
          d_wdata = $urandom();
        end
      end
      @(negedge clk);
      if (mem_if.m_req && !mreq_prev) begin
        chk("rnd_grant_has_req", 32'(prev_if | prev_d), 1);
        exp_d = prev_d && !(prev_if && mstarve == SMAX);
        chk("rnd_grant_addr", mem_if.m_addr, exp_d ? d_addr : if_addr);
        chk("rnd_grant_ctl", 32'({mem_if.m_we, mem_if.m_be}), exp_d ? 32'({d_we, d_be}) : 32'h0F);
        chk("rnd_grant_wdata", mem_if.m_wdata, exp_d ? d_wdata : 32'h0);
        if (exp_d) begin
          if (prev_if && mstarve < SMAX) mstarve++;
        end else begin
          mstarve = 0;
        end
        g_d = exp_d;
        rc_m = 0;
      end
      if (mem_if.m_req) rc_m++;
      if (pend) begin
        chk("rnd_valid_flags", 32'({if_valid, d_valid, bus_err}), 32'({!g_d, g_d, pend_to}));
        if (g_d) begin
          if (!pend_to) begin
            if (d_we) ref_write(d_addr, d_wdata, d_be);
            else exp_drd = ref_rd(d_addr);
          end
          chk("rnd_d_rdata", d_rdata, exp_drd);
          d_done = 1'b1;
        end else begin
          if (!pend_to) exp_ird = ref_rd(if_addr);
          chk("rnd_if_rdata", if_rdata, exp_ird);
          if_done = 1'b1;
        end
        pend = 1'b0;
      end else begin
        chk("rnd_no_valid", 32'({if_valid, d_valid, bus_err}), 0);
      end
      if (mem_if.m_req && (mem_if.m_ready || rc_m == TMO)) begin
        pend = 1'b1;
        pend_to = !mem_if.m_ready;
      end
      chk("rnd_stall", 32'({stall_if, stall_mem}), 32'({if_req & ~if_valid, d_req & ~d_valid}));
      prev_if = if_req; prev_d = d_req; mreq_prev = mem_if.m_req;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
